// File: rtl/key_event_gen.sv
// ============================================================================
// Module   : key_event_gen
// Function : turns a debounced key level into press / release / long-press /
//            auto-repeat single-cycle event pulses plus a held indicator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_gen #(
    parameter logic PRESSED_LEVEL = 1'b0,
    parameter int   LONG_TIME     = 50000000,
    parameter int   REPEAT_TIME   = 10000000,
    parameter int   CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level_i,
    input  logic repeat_en_i,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o,
    output logic repeat_pulse_o,
    output logic key_held_o
);

    typedef enum logic [1:0] {
        ST_WAIT_REL = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_LONG     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              held_q, held_d;
    logic              w_pressed;

    assign w_pressed = (key_level_i == PRESSED_LEVEL);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            // A key still down after reset must be released before it counts.
            ST_WAIT_REL: begin
                if (!w_pressed) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_pressed) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!w_pressed) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == C_LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_LONG: begin
                // Release has priority over a coincident repeat terminal count.
                if (!w_pressed) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (!repeat_en_i) begin
                    cnt_d = '0;
                end else if (cnt_q == C_REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_WAIT_REL;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT_REL;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;
    assign repeat_pulse_o  = repeat_q;
    assign key_held_o      = held_q;

endmodule

`default_nettype wire
